// File: rtl/mai_kick_addr_gen.sv
// Mai kick sprite: beam hit test, ROM address generation and
// vsync-paced kick animation sequencer with horizontal flip.
module mai_kick_addr_gen #(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 96,
  parameter int NUM_FRAMES = 4,
  parameter int HOLD_TICKS = 6,
  parameter int COOL_TICKS = 10,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int CMAX = (HOLD_TICKS > COOL_TICKS) ? HOLD_TICKS : COOL_TICKS,
  localparam int CW = $clog2(CMAX + 1)
) (
  input  logic          vga_clk,
  input  logic          reset_n,
  input  logic [9:0]    draw_x,
  input  logic [9:0]    draw_y,
  input  logic          blank,
  input  logic          vs,
  input  logic [9:0]    sprite_x,
  input  logic [9:0]    sprite_y,
  input  logic          flip,
  input  logic          kick_req,
  output logic [15:0]   rom_address,
  output logic          sprite_on,
  output logic          sprite_on_q,
  output logic [FW-1:0] frame_idx,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    COOL
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [FW-1:0] frame_q;
  logic          busy_q;
  logic          vs_q;
  logic          tick;

  assign tick = vs_q & ~vs;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      busy_q  <= 1'b0;
      vs_q    <= 1'b1;
    end else begin
      vs_q <= vs;
      unique case (state_q)
        IDLE: begin
          frame_q <= '0;
          cnt_q   <= '0;
          if (kick_req) begin
            state_q <= PLAY;
            busy_q  <= 1'b1;
          end
        end
        PLAY: begin
          if (tick) begin
            if (cnt_q == CW'(HOLD_TICKS - 1)) begin
              cnt_q <= '0;
              if (frame_q < FW'(NUM_FRAMES - 1)) begin
                frame_q <= frame_q + 1'b1;
              end else begin
                frame_q <= '0;
                state_q <= COOL;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        COOL: begin
          if (tick) begin
            if (cnt_q == CW'(COOL_TICKS - 1)) begin
              cnt_q   <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // 11-bit differences so a box past column 1023 clips instead of wrapping
  logic [10:0] dx;
  logic [10:0] dy;
  logic [10:0] col;
  logic        hit;
  logic [15:0] addr;

  logic [15:0] rom_address_d;
  logic        on_d;
  logic [15:0] rom_address_q;
  logic        on_q;
  logic        on_dly_q;

  always_comb begin
    dx  = {1'b0, draw_x} - {1'b0, sprite_x};
    dy  = {1'b0, draw_y} - {1'b0, sprite_y};
    hit = blank
        && (draw_x >= sprite_x) && (dx < 11'(SPR_W))
        && (draw_y >= sprite_y) && (dy < 11'(SPR_H));
    col = flip ? (11'(SPR_W - 1) - dx) : dx;
    addr = 16'(frame_q) * 16'(SPR_W * SPR_H)
         + 16'(dy) * 16'(SPR_W)
         + 16'(col);
    rom_address_d = hit ? addr : 16'd0;
    on_d = hit;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address_q <= '0;
      on_q          <= 1'b0;
      on_dly_q      <= 1'b0;
    end else begin
      rom_address_q <= rom_address_d;
      on_q          <= on_d;
      on_dly_q      <= on_q;
    end
  end

  assign rom_address = rom_address_q;
  assign sprite_on   = on_q;
  assign sprite_on_q = on_dly_q;
  assign frame_idx   = frame_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mai_kick_addr_gen.sv
// Bench for mai_kick_addr_gen: hit test, flip, animation,
// held kick, blanking/clipping and async reset.
module tb_mai_kick_addr_gen;

  logic        vga_clk;
  logic        reset_n;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic        blank;
  logic        vs;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic        flip;
  logic        kick_req;
  logic [15:0] rom_address;
  logic        sprite_on;
  logic        sprite_on_q;
  logic [1:0]  frame_idx;
  logic        busy;

  int n_chk;
  int n_fail;

  typedef struct packed {
    logic        on;
    logic [15:0] addr;
  } exp_t;

  exp_t sb[$];

  mai_kick_addr_gen dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .blank      (blank),
    .vs         (vs),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .flip       (flip),
    .kick_req   (kick_req),
    .rom_address(rom_address),
    .sprite_on  (sprite_on),
    .sprite_on_q(sprite_on_q),
    .frame_idx  (frame_idx),
    .busy       (busy)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  task automatic pix(input logic [9:0] x, input logic [9:0] y,
                     input logic eon, input logic [15:0] eaddr,
                     input string nm);
    exp_t e;
    @(negedge vga_clk);
    draw_x = x;
    draw_y = y;
    sb.push_back('{on: eon, addr: eaddr});
    @(posedge vga_clk);
    #1;
    e = sb.pop_front();
    n_chk++;
    if (rom_address !== e.addr) begin
      n_fail++;
      $display("FAIL %s rom_address got %0d want %0d", nm, rom_address, e.addr);
    end
    n_chk++;
    if (sprite_on !== e.on) begin
      n_fail++;
      $display("FAIL %s sprite_on got %b want %b", nm, sprite_on, e.on);
    end
    @(posedge vga_clk);
    #1;
    n_chk++;
    if (sprite_on_q !== e.on) begin
      n_fail++;
      $display("FAIL %s sprite_on_q got %b want %b", nm, sprite_on_q, e.on);
    end
  endtask

  task automatic vtick();
    @(negedge vga_clk);
    vs = 1'b1;
    @(negedge vga_clk);
    vs = 1'b0;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({rom_address, sprite_on, sprite_on_q, frame_idx, busy} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset outputs got %h want 0",
               {rom_address, sprite_on, sprite_on_q, frame_idx, busy});
    end
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  task automatic test_hit_noflip();
    sprite_x = 10'd100;
    sprite_y = 10'd50;
    flip = 1'b0;
    blank = 1'b1;
    pix(10'd100, 10'd50, 1'b1, 16'd0, "origin");
    pix(10'd163, 10'd51, 1'b1, 16'd127, "right_edge");
    pix(10'd164, 10'd51, 1'b0, 16'd0, "past_right");
    pix(10'd99, 10'd50, 1'b0, 16'd0, "left_of_box");
    pix(10'd100, 10'd49, 1'b0, 16'd0, "above_box");
    pix(10'd100, 10'd145, 1'b1, 16'd6080, "bottom_row");
    pix(10'd100, 10'd146, 1'b0, 16'd0, "below_box");
  endtask

  task automatic test_flip();
    flip = 1'b1;
    pix(10'd100, 10'd50, 1'b1, 16'd63, "flip_left");
    pix(10'd163, 10'd50, 1'b1, 16'd0, "flip_right");
    pix(10'd110, 10'd52, 1'b1, 16'd181, "flip_mid");
    flip = 1'b0;
  endtask

  task automatic test_blank_clip();
    blank = 1'b0;
    pix(10'd120, 10'd60, 1'b0, 16'd0, "blanked");
    blank = 1'b1;
    sprite_x = 10'd1000;
    for (int x = 0; x < 40; x++) begin
      pix(10'(x), 10'd60, 1'b0, 16'd0, "clip_wrap");
    end
    pix(10'd1000, 10'd60, 1'b1, 16'd640, "clip_left");
    pix(10'd1023, 10'd60, 1'b1, 16'd663, "clip_last");
    sprite_x = 10'd100;
  endtask

  task automatic test_anim();
    @(negedge vga_clk);
    kick_req = 1'b1;
    @(posedge vga_clk);
    #1;
    n_chk++;
    if (busy !== 1'b1 || frame_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL kick_start busy/frame got %b/%0d want 1/0", busy, frame_idx);
    end
    @(negedge vga_clk);
    kick_req = 1'b0;
    for (int t = 0; t < 24; t++) begin
      n_chk++;
      if (frame_idx !== 2'(t / 6)) begin
        n_fail++;
        $display("FAIL anim_frame t=%0d got %0d want %0d", t, frame_idx, t / 6);
      end
      if (t == 12) pix(10'd100, 10'd50, 1'b1, 16'd12288, "frame2_addr");
      if (t == 18) pix(10'd101, 10'd50, 1'b1, 16'd18433, "frame3_addr");
      vtick();
    end
    n_chk++;
    if (busy !== 1'b1 || frame_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL cool_entry busy/frame got %b/%0d want 1/0", busy, frame_idx);
    end
    repeat (9) vtick();
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cool_hold busy got %b want 1", busy);
    end
    vtick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cool_done busy got %b want 0", busy);
    end
  endtask

  task automatic test_held_kick();
    @(negedge vga_clk);
    kick_req = 1'b1;
    for (int t = 0; t < 33; t++) vtick();
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL held_cool busy got %b want 1", busy);
    end
    vtick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_idle busy got %b want 0", busy);
    end
    @(posedge vga_clk);
    #1;
    n_chk++;
    if (busy !== 1'b1 || frame_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL held_restart busy/frame got %b/%0d want 1/0", busy, frame_idx);
    end
    @(negedge vga_clk);
    kick_req = 1'b0;
    repeat (7) vtick();
    @(negedge vga_clk);
    kick_req = 1'b1;
    @(negedge vga_clk);
    kick_req = 1'b0;
    #1;
    n_chk++;
    if (frame_idx !== 2'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL play_kick busy/frame got %b/%0d want 1/1", busy, frame_idx);
    end
    repeat (5) vtick();
    n_chk++;
    if (frame_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL no_restart frame got %0d want 2", frame_idx);
    end
  endtask

  task automatic test_reset_mid_play();
    pix(10'd100, 10'd50, 1'b1, 16'd12288, "pre_reset");
    @(negedge vga_clk);
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({rom_address, sprite_on, sprite_on_q, frame_idx, busy} !== 21'd0) begin
      n_fail++;
      $display("FAIL mid_reset outputs got %h want 0",
               {rom_address, sprite_on, sprite_on_q, frame_idx, busy});
    end
    @(negedge vga_clk);
    reset_n = 1'b1;
    @(posedge vga_clk);
    #1;
    n_chk++;
    if (busy !== 1'b0 || frame_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL post_reset busy/frame got %b/%0d want 0/0", busy, frame_idx);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    draw_x = '0;
    draw_y = '0;
    blank = 1'b0;
    vs = 1'b1;
    sprite_x = '0;
    sprite_y = '0;
    flip = 1'b0;
    kick_req = 1'b0;
    test_reset();
    test_hit_noflip();
    test_flip();
    test_blank_clip();
    test_anim();
    test_held_kick();
    test_reset_mid_play();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
